// File: rtl/fetch_sequencer_pkg.sv
// Shared defaults, state encoding and the end-of-program marker for the fetch sequencer.
package fetch_sequencer_pkg;

  localparam int unsigned ROM_LAT_DEF  = 2;
  localparam int unsigned PC_STEP_DEF  = 4;
  localparam int unsigned RESET_PC_DEF = 4;

  // An all-zero instruction word marks the end of the program.
  localparam logic [31:0] HALT_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_HOLD,
    ST_HALT
  } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer_tag_pipe.sv
// Valid/pc shift register that tracks fetches in flight across the ROM read latency.
module fetch_tag_pipe #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              squash,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_pc,
  output logic              tail_valid,
  output logic [ADDR_W-1:0] tail_pc
);

  logic [DEPTH-1:0]  valid_q;
  logic [ADDR_W-1:0] pc_q [DEPTH];

  // Shift one stage per cycle; squash invalidates every stage including the one entering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid & ~squash;
      pc_q[0]    <= in_pc;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1] & ~squash;
        pc_q[i]    <= pc_q[i-1];
      end
    end
  end

  assign tail_valid = valid_q[DEPTH-1];
  assign tail_pc    = pc_q[DEPTH-1];

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter and fetch controller: drives the ROM address, pairs returning words
// with their tags and presents one instruction per cycle with a valid/stall handshake.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned RESET_PC = RESET_PC_DEF,
  parameter int unsigned PC_STEP  = PC_STEP_DEF,
  parameter int unsigned ROM_LAT  = ROM_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_instr,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              halted,
  output logic              misalign_err
);

  localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_d;
  logic              valid_d;
  logic [31:0]       instr_d;
  logic [ADDR_W-1:0] pc_d;
  logic              misalign_d;

  logic              tail_valid;
  logic [ADDR_W-1:0] tail_pc;
  logic              accept, redirect_req, halt_detect, redirect, misaligned;
  logic              hold_req, can_fetch, issue, squash;

  fetch_tag_pipe #(
    .DEPTH  (ROM_LAT),
    .ADDR_W (ADDR_W)
  ) u_tag_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .squash     (squash),
    .in_valid   (issue),
    .in_pc      (rom_addr),
    .tail_valid (tail_valid),
    .tail_pc    (tail_pc)
  );

  // Per-cycle event decode, in priority order: halt detect, redirect, stall, sequential.
  always_comb begin
    accept       = instr_valid & ~stall;
    redirect_req = accept & branch_taken & (state_q != ST_HALT);
    // A redirect discards the tail as wrong-path, so a zero word there is not the program end.
    halt_detect  = tail_valid & (rom_instr == HALT_WORD) & (state_q != ST_HALT) & ~redirect_req;
    redirect     = redirect_req;
    misaligned   = redirect & (branch_target[1:0] != 2'b00);
    hold_req     = instr_valid & stall & (state_q != ST_HALT) & ~halt_detect;
    can_fetch    = run & ((state_q == ST_FETCH) | ((state_q == ST_HOLD) & ~stall));
    issue        = can_fetch & ~halt_detect & ~redirect & ~hold_req;
    squash       = halt_detect | redirect | hold_req;
  end

  // Next state, next ROM address and next output register contents.
  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr;
    valid_d    = instr_valid;
    instr_d    = instr;
    pc_d       = instr_pc;
    misalign_d = misalign_err;

    if (halt_detect) begin
      state_d = ST_HALT;
      if (accept) valid_d = 1'b0;
    end else if (redirect) begin
      valid_d = 1'b0;
      if (misaligned) begin
        state_d    = ST_HALT;
        misalign_d = 1'b1;
      end else begin
        rom_addr_d = branch_target;
        state_d    = run ? ST_FETCH : ST_IDLE;
      end
    end else if (hold_req) begin
      // Refetch resumes right after the held instruction once the consumer is ready.
      rom_addr_d = instr_pc + STEP;
      state_d    = ST_HOLD;
    end else begin
      if (tail_valid && !(instr_valid && stall)) begin
        valid_d = 1'b1;
        instr_d = rom_instr;
        pc_d    = tail_pc;
      end else if (accept) begin
        valid_d = 1'b0;
      end
      if (issue) rom_addr_d = rom_addr + STEP;
      if (state_q != ST_HALT) state_d = run ? ST_FETCH : ST_IDLE;
    end
  end

  // State, address and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rom_addr     <= RESET_ADDR;
      instr_valid  <= 1'b0;
      instr        <= '0;
      instr_pc     <= '0;
      misalign_err <= 1'b0;
    end else begin
      state_q      <= state_d;
      rom_addr     <= rom_addr_d;
      instr_valid  <= valid_d;
      instr        <= instr_d;
      instr_pc     <= pc_d;
      misalign_err <= misalign_d;
    end
  end

  assign halted = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a queue-based behavioural model.
module tb_fetch_sequencer;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [7:0]  branch_target = 8'd0;
  logic [7:0]  rom_addr, instr_pc;
  logic [31:0] rom_instr, instr;
  logic        instr_valid, halted, misalign_err;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .ADDR_W   (8),
    .RESET_PC (4),
    .PC_STEP  (4),
    .ROM_LAT  (LAT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .run           (run),
    .rom_addr      (rom_addr),
    .rom_instr     (rom_instr),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .halted        (halted),
    .misalign_err  (misalign_err)
  );

  // ROM with two read registers.
  logic [31:0] mem [64];
  logic [31:0] rd1 = '0, rd2 = '0;
  always @(posedge clk) begin
    rd1 <= mem[rom_addr[7:2]];
    rd2 <= rd1;
  end
  assign rom_instr = rd2;

  // Behavioural model: in-flight fetches are a queue of {pc, cycle the word returns}.
  typedef struct { logic [7:0] pc; int due; } flight_t;
  flight_t     fl[$];
  int          cyc;
  bit          m_fetch, m_hold;
  bit          e_valid, e_halt, e_mis;
  logic [31:0] e_instr;
  logic [7:0]  e_pc, e_addr;

  task automatic model_reset();
    fl.delete();
    cyc = 0; m_fetch = 0; m_hold = 0;
    e_valid = 0; e_halt = 0; e_mis = 0; e_instr = '0; e_pc = '0; e_addr = 8'd4;
  endtask

  task automatic model_step();
    bit tv, acc, hd, br, hold, can;
    logic [7:0]  tpc;
    logic [31:0] w;
    tv = 0; tpc = '0;
    if (fl.size() > 0 && fl[0].due == cyc) begin
      tv = 1; tpc = fl[0].pc; fl.delete(0);
    end
    w    = mem[tpc[7:2]];
    acc  = e_valid && !stall;
    br   = acc && branch_taken && !e_halt;
    hd   = tv && w == 32'd0 && !e_halt && !br;
    hold = e_valid && stall && !e_halt && !hd;
    can  = run && !e_halt && (m_fetch || (m_hold && !stall));
    if (hd) begin
      e_halt = 1; fl.delete();
      if (acc) e_valid = 0;
    end else if (br) begin
      fl.delete(); e_valid = 0;
      if (branch_target[1:0] != 2'b00) begin
        e_halt = 1; e_mis = 1;
      end else begin
        e_addr = branch_target; m_fetch = run; m_hold = 0;
      end
    end else if (hold) begin
      fl.delete(); e_addr = e_pc + 8'd4; m_hold = 1; m_fetch = 0;
    end else begin
      if (tv) begin
        e_valid = 1; e_instr = w; e_pc = tpc;
      end else if (acc) begin
        e_valid = 0;
      end
      if (can) begin
        fl.push_back('{pc: e_addr, due: cyc + LAT});
        e_addr = e_addr + 8'd4;
      end
      m_fetch = run; m_hold = 0;
    end
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("rom_addr", 32'(rom_addr), 32'(e_addr));
    chk("instr_valid", 32'(instr_valid), 32'(e_valid));
    chk("halted", 32'(halted), 32'(e_halt));
    chk("misalign_err", 32'(misalign_err), 32'(e_mis));
    if (e_valid) begin
      chk("instr", instr, e_instr);
      chk("instr_pc", 32'(instr_pc), 32'(e_pc));
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic load_program();
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013 | (32'(i) << 7);
    mem[0]  = 32'h0;
    mem[12] = 32'h0042_8333;
    mem[24] = 32'h0;
  endtask

  task automatic rand_program();
    for (int i = 0; i < 64; i++)
      mem[i] = ($urandom_range(0, 29) == 0) ? 32'h0 : ($urandom | 32'h1);
    mem[0] = 32'h0;
  endtask

  task automatic do_reset(input bit rnd);
    rst_n = 0; run = 0; stall = 0; branch_taken = 0; branch_target = '0;
    if (rnd) rand_program();
    model_reset();
    @(negedge clk);
    compare_all();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic wait_pc(input logic [7:0] p, input int budget);
    int n;
    n = 0;
    while (!(instr_valid && instr_pc == p) && n < budget) begin
      tick(); n++;
    end
    chk($sformatf("reach_pc_%0d", p), 32'(instr_valid && instr_pc == p), 32'd1);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin tick(); n++; end while (!instr_valid && n < 12);
  endtask

  initial begin
    int   n, hcnt;
    bit   saw96;
    logic [7:0] last_pc;

    // Directed: reset values, first fetch latency, stall hold, end-of-program halt.
    load_program();
    do_reset(0);
    chk("rst_addr", 32'(rom_addr), 32'd4);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", 32'(instr_pc), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_mis", 32'(misalign_err), 32'd0);
    run = 1;
    wait_valid(n);
    chk("first_valid_latency", 32'(n), 32'd4);
    chk("first_pc", 32'(instr_pc), 32'd4);
    chk("first_instr", instr, 32'h0000_0093);
    wait_pc(8'd20, 20);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", 32'(instr_pc), 32'd20);
      chk("stall_valid", 32'(instr_valid), 32'd1);
    end
    stall = 0;
    wait_valid(n);
    chk("refill_latency", 32'(n), 32'd3);
    chk("refill_pc", 32'(instr_pc), 32'd24);
    saw96 = 0; last_pc = instr_pc; n = 0;
    while (!halted && n < 40) begin
      tick(); n++;
      if (instr_valid) begin
        last_pc = instr_pc;
        if (instr_pc == 8'd96) saw96 = 1;
      end
    end
    chk("end_halted", 32'(halted), 32'd1);
    chk("end_last_pc", 32'(last_pc), 32'd92);
    chk("end_no_96", 32'(saw96), 32'd0);
    chk("end_valid", 32'(instr_valid), 32'd0);
    chk("end_addr", 32'(rom_addr), 32'd104);
    repeat (3) tick();

    // Directed: asynchronous reset mid-stream, then restart from the reset pc.
    do_reset(0);
    run = 1;
    wait_pc(8'd40, 20);
    #2 rst_n = 0;
    #1;
    chk("async_addr", 32'(rom_addr), 32'd4);
    chk("async_valid", 32'(instr_valid), 32'd0);
    chk("async_instr", instr, 32'd0);
    chk("async_pc", 32'(instr_pc), 32'd0);
    chk("async_halted", 32'(halted), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    wait_valid(n);
    chk("restart_pc", 32'(instr_pc), 32'd4);

    // Directed: branch ignored under stall, taken branch, misaligned branch.
    do_reset(0);
    run = 1;
    wait_pc(8'd48, 20);
    stall = 1; branch_taken = 1; branch_target = 8'h30;
    tick();
    chk("stall_br_pc", 32'(instr_pc), 32'd48);
    stall = 0; branch_taken = 0;
    wait_valid(n);
    chk("stall_br_next", 32'(instr_pc), 32'd52);
    wait_pc(8'd92, 20);
    branch_taken = 1; branch_target = 8'h30;
    tick();
    branch_taken = 0;
    wait_valid(n);
    chk("br_bubble", 32'(n), 32'd3);
    chk("br_pc", 32'(instr_pc), 32'h30);
    chk("br_instr", instr, 32'h0042_8333);
    chk("br_not_halted", 32'(halted), 32'd0);
    branch_taken = 1; branch_target = 8'h31;
    tick();
    branch_taken = 0;
    chk("mis_err", 32'(misalign_err), 32'd1);
    chk("mis_halted", 32'(halted), 32'd1);
    chk("mis_valid", 32'(instr_valid), 32'd0);
    chk("mis_addr", 32'(rom_addr), 32'h3C);
    repeat (2) tick();
    chk("mis_addr_frozen", 32'(rom_addr), 32'h3C);

    // Randomized traffic against the model; reset a few cycles after each halt.
    do_reset(1);
    hcnt = 0;
    for (int i = 0; i < 1500; i++) begin
      run          = ($urandom_range(0, 19) != 0);
      stall        = ($urandom_range(0, 3) == 0);
      branch_taken = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) branch_target = 8'($urandom_range(0, 255)) | 8'h01;
      else                            branch_target = {6'($urandom_range(0, 63)), 2'b00};
      tick();
      hcnt = halted ? hcnt + 1 : 0;
      if (hcnt > 6) begin
        do_reset(1);
        hcnt = 0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1);
  end

endmodule
